pipe_credit_ctrl: RTL and testbench

PIPE_CREDIT_CTRL -- requirements
Module: pipe_credit_ctrl

---
 rtl/pipe_credit_pkg.sv | 12 +
 rtl/pipe_credit_fifo.sv | 43 ++++
 rtl/pipe_credit_ctrl.sv | 74 +++++++
 tb/tb_pipe_credit_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_credit_pkg.sv
// pipe_credit_pkg: shared constants and width helper for the credit controller
package pipe_credit_pkg;
   localparam int C_LATENCY_MAX = 32;
   localparam int ERR_OVF       = 0;
   localparam int ERR_ORPHAN    = 1;
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo: first-word-fall-through result buffer with occupancy count
module pipe_credit_fifo
   import pipe_credit_pkg::*;
#(
   parameter int C_WIDTH = 16,
   parameter int C_DEPTH = 8,
   localparam int AW = clog2(C_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wr,
   input  logic [C_WIDTH-1:0] i_wdata,
   input  logic               i_rd,
   output logic               o_empty,
   output logic               o_full,
   output logic [AW:0]        o_count,
   output logic [C_WIDTH-1:0] o_rdata
);
   logic [C_WIDTH-1:0] r_mem [2**AW];
   logic [AW:0]        r_wptr;
   logic [AW:0]        r_rptr;
   logic               w_wr_en;
   logic               w_rd_en;
   assign o_count = r_wptr - r_rptr;
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (o_count == (AW+1)'(C_DEPTH));
   assign w_wr_en = i_wr & (~o_full | i_rd);
   assign w_rd_en = i_rd & ~o_empty;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   // pointers carry one extra bit so full and empty stay distinguishable after wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
            r_wptr                <= r_wptr + (AW+1)'(1);
         end
         if (w_rd_en) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/pipe_credit_ctrl.sv
// pipe_credit_ctrl: credit-based flow control around a fixed-latency non-stalling datapath
module pipe_credit_ctrl
   import pipe_credit_pkg::*;
#(
   parameter int C_LATENCY    = 4,
   parameter int C_WIDTH      = 16,
   parameter int C_FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   output logic               pipe_ce,
   output logic               pipe_valid_in,
   input  logic               pipe_valid_out,
   input  logic [C_WIDTH-1:0] pipe_data_out,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [C_WIDTH-1:0] m_data,
   output logic               busy,
   output logic [1:0]         err
);
   localparam int AW = clog2(C_FIFO_DEPTH);
   localparam int LW = clog2(C_LATENCY_MAX + 1);
   logic [AW:0]        r_inflight;
   logic [LW-1:0]      r_blank;
   logic [1:0]         r_err;
   logic [AW:0]        w_count;
   logic [AW+1:0]      w_used;
   logic               w_empty;
   logic               w_full;
   logic               w_pvo;
   logic               w_orphan;
   logic               w_pop;
   logic [C_WIDTH-1:0] w_head;
   assign w_used        = {1'b0, w_count} + {1'b0, r_inflight};
   assign s_ready       = ~rst & (w_used < (AW+2)'(C_FIFO_DEPTH));
   assign pipe_valid_in = s_valid & s_ready;
   assign pipe_ce       = ~rst;
   assign w_pvo         = pipe_valid_out & (r_blank == '0);
   assign w_orphan      = w_pvo & (r_inflight == '0);
   assign m_valid       = ~rst & ~w_empty;
   assign w_pop         = m_valid & m_ready;
   assign m_data        = m_valid ? w_head : '0;
   assign busy          = ~rst & ((r_inflight != '0) | ~w_empty);
   assign err           = rst ? 2'b00 : r_err;
   pipe_credit_fifo #(
      .C_WIDTH (C_WIDTH),
      .C_DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_pvo),
      .i_wdata (pipe_data_out),
      .i_rd    (w_pop),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count),
      .o_rdata (w_head)
   );
   // inflight tracking, post-reset blanking of stale delay-line output, sticky errors
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
         r_blank    <= LW'(C_LATENCY);
         r_err      <= '0;
      end else begin
         r_inflight <= r_inflight + (AW+1)'(pipe_valid_in) - (AW+1)'(w_pvo & ~w_orphan);
         r_blank    <= (r_blank != '0) ? r_blank - LW'(1) : r_blank;
         if (w_pvo & w_full & ~w_pop) r_err[ERR_OVF] <= 1'b1;
         if (w_orphan) r_err[ERR_ORPHAN] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// tb_pipe_credit_ctrl: directed and random checks of the credit controller against a queue model
module tb_pipe_credit_ctrl;
   localparam int LA = 4;
   localparam int DA = 8;
   localparam int LB = 1;
   localparam int DB = 1;
   localparam int W  = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s_valid = 1'b0;
   logic m_ready = 1'b0;
   logic force_a = 1'b0;
   logic ghost = 1'b0;
   logic sel = 1'b0;
   logic [W-1:0] s_data = '0;
   always #5 clk = ~clk;
   logic a_sr, a_ce, a_vin, a_mv, a_busy;
   logic [1:0] a_err;
   logic [W-1:0] a_md;
   logic [LA-1:0] a_dv;
   logic [W-1:0] a_dd [LA];
   logic b_sr, b_ce, b_vin, b_mv, b_busy, b_v;
   logic [1:0] b_err;
   logic [W-1:0] b_md, b_d;
   pipe_credit_ctrl #(.C_LATENCY(LA), .C_WIDTH(W), .C_FIFO_DEPTH(DA)) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_sr), .pipe_ce(a_ce),
      .pipe_valid_in(a_vin), .pipe_valid_out(a_dv[LA-1] | force_a | ghost),
      .pipe_data_out(a_dd[LA-1]), .m_valid(a_mv), .m_ready(m_ready), .m_data(a_md),
      .busy(a_busy), .err(a_err));
   pipe_credit_ctrl #(.C_LATENCY(LB), .C_WIDTH(W), .C_FIFO_DEPTH(DB)) dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_sr), .pipe_ce(b_ce),
      .pipe_valid_in(b_vin), .pipe_valid_out(b_v), .pipe_data_out(b_d),
      .m_valid(b_mv), .m_ready(m_ready), .m_data(b_md), .busy(b_busy), .err(b_err));
   // external identity datapaths with their valid delay lines
   always @(posedge clk) begin
      if (rst) a_dv <= '0;
      else if (a_ce) begin
         a_dv <= {a_dv[LA-2:0], a_vin};
         a_dd[0] <= s_data;
         for (int i = 1; i < LA; i++) a_dd[i] <= a_dd[i-1];
      end
   end
   always @(posedge clk) begin
      if (rst) b_v <= 1'b0;
      else if (b_ce) begin
         b_v <= b_vin;
         b_d <= s_data;
      end
   end
   logic sr, ce, vin, mv, bsy;
   logic [1:0] er;
   logic [W-1:0] md;
   assign sr  = sel ? b_sr : a_sr;
   assign ce  = sel ? b_ce : a_ce;
   assign vin = sel ? b_vin : a_vin;
   assign mv  = sel ? b_mv : a_mv;
   assign bsy = sel ? b_busy : a_busy;
   assign er  = sel ? b_err : a_err;
   assign md  = sel ? b_md : a_md;
   int total = 0;
   int bad = 0;
   int L, D, cyc, d_acc, d_out, n_acc, first_mv, a0, o0, n0;
   int due_q[$];
   logic [W-1:0] inf_d[$];
   logic [W-1:0] fq[$];
   logic [1:0] exp_err;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cycle();
      logic e_sr, acc, pop, orph;
      logic [W-1:0] orph_d;
      @(negedge clk);
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         fq.push_back(inf_d.pop_front());
      end
      e_sr = (fq.size() + due_q.size()) < D;
      chk("s_ready", 32'(sr), 32'(e_sr));
      chk("pipe_ce", 32'(ce), 32'd1);
      chk("pipe_valid_in", 32'(vin), 32'(s_valid & e_sr));
      chk("m_valid", 32'(mv), 32'(fq.size() > 0));
      if (fq.size() > 0) chk("m_data", 32'(md), 32'(fq[0]));
      chk("busy", 32'(bsy), 32'((fq.size() + due_q.size()) > 0));
      chk("err", 32'(er), 32'(exp_err));
      d_acc += int'(s_valid & sr);
      d_out += int'(mv & m_ready);
      if (mv && first_mv < 0) first_mv = cyc;
      acc = s_valid & e_sr;
      pop = m_ready & (fq.size() > 0);
      orph = force_a;
      orph_d = a_dd[LA-1];
      if (acc) begin
         due_q.push_back(cyc + L + 1);
         inf_d.push_back(s_data);
         n_acc++;
      end
      if (pop) void'(fq.pop_front());
      if (orph) begin
         fq.push_back(orph_d);
         exp_err[1] = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) begin
         @(negedge clk);
         chk("rst_s_ready", 32'(sr), 32'd0);
         chk("rst_pipe_ce", 32'(ce), 32'd0);
         chk("rst_valid_in", 32'(vin), 32'd0);
         chk("rst_m_valid", 32'(mv), 32'd0);
         chk("rst_m_data", 32'(md), 32'd0);
         chk("rst_busy", 32'(bsy), 32'd0);
         chk("rst_err", 32'(er), 32'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      due_q.delete();
      inf_d.delete();
      fq.delete();
      exp_err = 2'b00;
      cyc = 0;
   endtask
   initial begin
      L = LA; D = DA; d_acc = 0; d_out = 0; n_acc = 0; first_mv = -1; exp_err = 2'b00; cyc = 0;
      s_valid = 1'b1;
      do_reset(3);
      s_data = 16'h1234; m_ready = 1'b1;
      cycle();
      s_valid = 1'b0;
      repeat (10) cycle();
      chk("first_latency", 32'(first_mv), 32'(LA + 1));
      a0 = d_acc; o0 = d_out; s_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_data = 16'(100 + i);
         cycle();
      end
      s_valid = 1'b0;
      repeat (10) cycle();
      chk("b2b_accepts", 32'(d_acc - a0), 32'd20);
      chk("b2b_outputs", 32'(d_out - o0), 32'd20);
      a0 = d_acc; s_valid = 1'b1; m_ready = 1'b0;
      repeat (14) begin
         s_data = 16'($urandom);
         cycle();
      end
      chk("fill_accepts", 32'(d_acc - a0), 32'd8);
      chk("fill_s_ready", 32'(sr), 32'd0);
      chk("fill_err", 32'(er), 32'd0);
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
      repeat (6) cycle();
      chk("pulse_accepts", 32'(d_acc - a0), 32'd9);
      s_valid = 1'b0; m_ready = 1'b1;
      repeat (15) cycle();
      repeat (400) begin
         s_valid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         s_data = 16'($urandom);
         cycle();
      end
      s_valid = 1'b0; m_ready = 1'b1;
      repeat (15) cycle();
      chk("rand_accepts", 32'(d_acc), 32'(n_acc));
      force_a = 1'b1;
      cycle();
      force_a = 1'b0;
      repeat (4) cycle();
      chk("orphan_err", 32'(er), 32'd2);
      s_valid = 1'b1; m_ready = 1'b0;
      repeat (5) begin
         s_data = 16'($urandom);
         cycle();
      end
      s_valid = 1'b0;
      repeat (2) cycle();
      chk("pre_rst_m_valid", 32'(mv), 32'd1);
      chk("pre_rst_busy", 32'(bsy), 32'd1);
      s_valid = 1'b1;
      do_reset(2);
      s_valid = 1'b0; m_ready = 1'b1; o0 = d_out;
      cycle();
      ghost = 1'b1;
      cycle();
      ghost = 1'b0;
      repeat (8) cycle();
      chk("post_rst_outputs", 32'(d_out - o0), 32'd0);
      chk("post_rst_err", 32'(er), 32'd0);
      sel = 1'b1; L = LB; D = DB; s_valid = 1'b1;
      do_reset(2);
      a0 = d_acc; n0 = n_acc; o0 = d_out; m_ready = 1'b1;
      repeat (30) begin
         s_data = 16'($urandom);
         cycle();
      end
      s_valid = 1'b0;
      repeat (5) cycle();
      chk("small_accepts_model", 32'(d_acc - a0), 32'(n_acc - n0));
      chk("small_accept_rate", 32'(d_acc - a0), 32'd10);
      chk("small_outputs", 32'(d_out - o0), 32'd10);
      chk("small_err", 32'(er), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
